// File: rtl/bit64_and_if.sv
// ---------------------------------------------------------------------------
// bit64_and_if
// Operand/result bundle for the bit64_and block.
//
// Signals:
//   a, b    operands (two's-complement, WIDTH bits)
//   cc_en   condition-code update enable, sampled on the rising clk edge
//   bitand  combinational result a & b
//   zf      registered zero flag
//   sf      registered sign flag
//   of      registered overflow flag
//
// Handshake: there is no valid/ready pair. The operands are always
// considered valid and bitand follows them combinationally; cc_en acts as
// the single qualifier that tells the block to capture flags at the next
// rising clk edge. With cc_en low the flags simply hold.
//
// Modports:
//   master  drives a, b, cc_en; observes the result and flags
//   slave   the AND block itself
// ---------------------------------------------------------------------------
interface bit64_and_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cc_en;
    logic [WIDTH-1:0] bitand;
    logic             zf;
    logic             sf;
    logic             of;

    modport master (
        output a,
        output b,
        output cc_en,
        input  bitand,
        input  zf,
        input  sf,
        input  of
    );

    modport slave (
        input  a,
        input  b,
        input  cc_en,
        output bitand,
        output zf,
        output sf,
        output of
    );
endinterface

// File: rtl/bit64_and.sv
// ---------------------------------------------------------------------------
// bit64_and
// Bitwise AND of two signed operands with registered condition codes.
//
// Ports:
//   clk   rising-edge clock for the flag registers
//   rst   synchronous, active-high reset of the flags
//   bus   bit64_and_if.slave: a, b, cc_en in; bitand, zf, sf, of out
//
// bitand is purely combinational and never touched by clk, rst or cc_en.
// The flags are captured from the same a & b value on an edge where
// cc_en=1 (one cycle behind bitand) and hold otherwise. rst wins over cc_en.
// ---------------------------------------------------------------------------
module bit64_and #(
    parameter int WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    bit64_and_if.slave  bus
);
    logic [WIDTH-1:0] and_result;
    logic             zf_q;
    logic             sf_q;
    logic             of_q;

    // Sign plays no part: the MSB is ANDed like every other bit.
    always_comb begin
        and_result = bus.a & bus.b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b0;
            sf_q <= 1'b0;
            of_q <= 1'b0;
        end else if (bus.cc_en) begin
            zf_q <= (and_result == '0);
            sf_q <= and_result[WIDTH-1];
            // A logical AND can never overflow.
            of_q <= 1'b0;
        end
    end

    assign bus.bitand = and_result;
    assign bus.zf     = zf_q;
    assign bus.sf     = sf_q;
    assign bus.of     = of_q;
endmodule

// File: tb/tb_bit64_and.sv
module tb_bit64_and;
  localparam int W = 64;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference flag state, advanced only by the tick task.
  logic m_zf, m_sf, m_of;

  bit64_and_if #(.WIDTH(W)) bus ();

  bit64_and #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_and(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[i] && y[i];
    return r;
  endfunction

  // Advance the model on the coming edge, then wait until 1 time unit after it.
  task automatic tick();
    logic [W-1:0] r;
    r = model_and(bus.a, bus.b);
    if (rst) begin
      m_zf = 1'b0; m_sf = 1'b0; m_of = 1'b0;
    end else if (bus.cc_en) begin
      m_zf = (r == 0);
      m_sf = ($signed(r) < 0);
      m_of = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] y, input logic en);
    bus.a = x;
    bus.b = y;
    bus.cc_en = en;
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(64'h1234_5678_9ABC_DEF0, 64'hFFFF_0000_FFFF_0000, 1'b1);
    tick();
    tick();
    checks++;
    if ({bus.zf, bus.sf, bus.of} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b exp=000", {bus.zf, bus.sf, bus.of});
    end
    checks++;
    if (bus.bitand !== 64'h1234_0000_9ABC_0000) begin
      errors++; $display("FAIL reset_bitand got=%h exp=%h", bus.bitand, 64'h1234_0000_9ABC_0000);
    end
    rst = 1'b0;
  endtask

  task automatic test_f0cc();
    drive(64'hF0F0_F0F0_F0F0_F0F4, 64'hCCCC_CCCC_CCCC_CCC5, 1'b1);
    checks++;
    if (bus.bitand !== 64'hC0C0_C0C0_C0C0_C0C4) begin
      errors++; $display("FAIL f0cc_bitand got=%h exp=c0c0c0c0c0c0c0c4", bus.bitand);
    end
    tick();
    checks++;
    if ({bus.zf, bus.sf, bus.of} !== 3'b010) begin
      errors++; $display("FAIL f0cc_flags got=%b exp=010", {bus.zf, bus.sf, bus.of});
    end
  endtask

  task automatic test_decimal();
    logic [W-1:0] x, y, e;
    x = 64'sd746454534454545127;
    y = -64'sd876348766845459288;
    e = model_and(x, y);
    drive(x, y, 1'b1);
    checks++;
    if (bus.bitand !== e) begin
      errors++; $display("FAIL decimal_bitand got=%h exp=%h", bus.bitand, e);
    end
    tick();
    checks++;
    if ({bus.zf, bus.sf, bus.of} !== {1'b0, e[W-1], 1'b0}) begin
      errors++; $display("FAIL decimal_flags got=%b exp=%b", {bus.zf, bus.sf, bus.of}, {1'b0, e[W-1], 1'b0});
    end
  endtask

  task automatic test_zero_result();
    drive(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b1);
    checks++;
    if (bus.bitand !== 64'h0) begin
      errors++; $display("FAIL zero_bitand got=%h exp=0", bus.bitand);
    end
    tick();
    checks++;
    if ({bus.zf, bus.sf, bus.of} !== 3'b100) begin
      errors++; $display("FAIL zero_flags got=%b exp=100", {bus.zf, bus.sf, bus.of});
    end
  endtask

  task automatic test_cc_en_hold();
    rst = 1'b1;
    drive(64'h0, 64'h0, 1'b0);
    tick();
    rst = 1'b0;
    drive(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0);
    tick();
    checks++;
    if (bus.bitand !== 64'h8000_0000_0000_0001) begin
      errors++; $display("FAIL hold_bitand got=%h exp=8000000000000001", bus.bitand);
    end
    checks++;
    if ({bus.zf, bus.sf, bus.of} !== 3'b000) begin
      errors++; $display("FAIL hold_flags got=%b exp=000", {bus.zf, bus.sf, bus.of});
    end
  endtask

  task automatic test_reset_priority();
    drive(64'h0F0F, 64'hF0F0, 1'b1);
    tick();
    checks++;
    if (bus.zf !== 1'b1) begin
      errors++; $display("FAIL prio_setup_zf got=%b exp=1", bus.zf);
    end
    rst = 1'b1;
    drive(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    tick();
    checks++;
    if ({bus.zf, bus.sf, bus.of} !== 3'b000) begin
      errors++; $display("FAIL prio_flags got=%b exp=000", {bus.zf, bus.sf, bus.of});
    end
    drive(64'hDEAD_BEEF_0000_FFFF, 64'hFFFF_0000_FFFF_F00F, 1'b1);
    checks++;
    if (bus.bitand !== 64'hDEAD_0000_0000_F00F) begin
      errors++; $display("FAIL prio_bitand got=%h exp=dead00000000f00f", bus.bitand);
    end
    rst = 1'b0;
  endtask

  // rst raised and dropped between edges must not clear the flags.
  task automatic test_reset_no_edge();
    drive(64'hF000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1);
    tick();
    checks++;
    if ({bus.zf, bus.sf, bus.of} !== 3'b010) begin
      errors++; $display("FAIL noedge_setup got=%b exp=010", {bus.zf, bus.sf, bus.of});
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.zf, bus.sf, bus.of} !== 3'b010) begin
      errors++; $display("FAIL noedge_flags got=%b exp=010", {bus.zf, bus.sf, bus.of});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, e;
    logic         en;
    for (int n = 0; n < 1000; n++) begin
      x  = {$urandom, $urandom};
      y  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) y = ~x;
      en = ($urandom_range(0, 3) != 0);
      drive(x, y, en);
      e = model_and(x, y);
      checks++;
      if (bus.bitand !== e) begin
        errors++; $display("FAIL rand_bitand n=%0d got=%h exp=%h", n, bus.bitand, e);
      end
      tick();
      checks++;
      if ({bus.zf, bus.sf, bus.of} !== {m_zf, m_sf, m_of}) begin
        errors++; $display("FAIL rand_flags n=%0d got=%b exp=%b", n, {bus.zf, bus.sf, bus.of}, {m_zf, m_sf, m_of});
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    checks = 0;
    errors = 0;
    m_zf = 1'b0; m_sf = 1'b0; m_of = 1'b0;
    rst = 1'b1;
    bus.a = '0;
    bus.b = '0;
    bus.cc_en = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_f0cc();
    test_decimal();
    test_zero_result();
    test_cc_en_hold();
    test_reset_priority();
    test_reset_no_edge();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit64_and.md
BIT64_AND -- requirements
Module: bit64_and

Interface
REQ-001 Parameter: WIDTH, default 64, operand/result width; only 64 is required to be supported.
REQ-002 Port: clk  input  1  rising-edge clock for the flag registers.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: a  input  64  operand A, two's-complement signed.
REQ-005 Port: b  input  64  operand B, two's-complement signed.
REQ-006 Port: cc_en  input  1  condition-code update enable, sampled on the rising clk edge.
REQ-007 Port: bitand  output  64  signed result, a AND b.
REQ-008 Port: zf  output  1  registered zero flag.
REQ-009 Port: sf  output  1  registered sign flag.
REQ-010 Port: of  output  1  registered overflow flag.

Function
REQ-011 bitand SHALL equal the bitwise AND of a and b, bit i = a[i] & b[i] for i = 0..63.
REQ-012 bitand SHALL be purely combinational, with zero clock latency, and SHALL be independent of clk, rst and cc_en.
REQ-013 bitand SHALL settle within the same simulation time step as any change on a or b, with no latch and no retained state.
REQ-014 Sign SHALL play no part in the computation; bit 63 is ANDed like any other bit, and a negative AND negative yields a negative result.
REQ-015 On a rising clk edge with rst=0 and cc_en=1, zf SHALL load (bitand == 0).
REQ-016 On the same edge, sf SHALL load bitand[63].
REQ-017 On the same edge, of SHALL load 0, because a logical AND cannot overflow.
REQ-018 On a rising clk edge with rst=0 and cc_en=0, zf, sf and of SHALL hold their values.
REQ-019 Flag outputs SHALL reflect the operands present at the capturing edge, giving one-cycle latency relative to bitand.
REQ-020 The block SHALL contain no X-propagation beyond the inputs: known a and b give a known bitand.

Reset
REQ-021 When rst=1 at a rising clk edge, zf, sf and of SHALL all become 0.
REQ-022 rst SHALL have priority over cc_en.
REQ-023 rst SHALL NOT affect bitand, which keeps tracking a & b during reset.
REQ-024 Reset SHALL be synchronous only; an asserted rst with no clk edge SHALL leave the flags unchanged.
REQ-025 Flag values before the first reset are undefined; the bench SHALL apply rst before checking flags.

Verification
REQ-026 a=0xF0F0F0F0F0F0F0F4, b=0xCCCCCCCCCCCCCCC5 -> bitand=0xC0C0C0C0C0C0C0C4 (negative), with no clock edge required; after an edge with cc_en=1 -> zf=0, sf=1, of=0.
REQ-027 a=746454534454545127 (decimal), b=-876348766845459288 (decimal) -> bitand equals the bit-for-bit AND model on all 64 bits; after an edge with cc_en=1 -> sf=bitand[63], zf=0.
REQ-028 a=0xAAAAAAAAAAAAAAAA, b=0x5555555555555555, cc_en=1, one edge -> bitand=0, zf=1, sf=0, of=0.
REQ-029 a=0xFFFFFFFFFFFFFFFF, b=0x8000000000000001, cc_en=0, one edge after reset -> bitand=0x8000000000000001, while zf, sf and of stay 0.
REQ-030 Flags set (zf=1), then rst=1 held for one edge with cc_en=1 -> zf=sf=of=0, while bitand keeps following the inputs.
REQ-031 Random sweep of 1000 operand pairs, checked every time step -> bitand == a & b, and flags match the model one edge later when cc_en=1.
